// File: rtl/gpio_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner_if
// Groups the board-side inputs and the PS GPIO handshake bits of the input
// conditioner into one bundle.
//   raw_in        : asynchronous board inputs (buttons/switches), active-high
//   ack_toggle    : PS GPIO bit, every transition requests one clear
//   ack_mask      : PS GPIO bits, which event bits the next clear affects
//   level_out     : debounced input level
//   event_pending : sticky per-bit change flags
//   ack_echo      : synchronized ack_toggle, follows it once the clear is done
//   irq           : OR of event_pending
// master = board/PS side, slave = conditioner.
// -----------------------------------------------------------------------------
interface gpio_input_conditioner_if #(
   parameter int WIDTH = 6
);
   logic [WIDTH-1:0] raw_in;
   logic             ack_toggle;
   logic [WIDTH-1:0] ack_mask;
   logic [WIDTH-1:0] level_out;
   logic [WIDTH-1:0] event_pending;
   logic             ack_echo;
   logic             irq;

   modport master (
      output raw_in, ack_toggle, ack_mask,
      input  level_out, event_pending, ack_echo, irq
   );

   modport slave (
      input  raw_in, ack_toggle, ack_mask,
      output level_out, event_pending, ack_echo, irq
   );
endinterface

// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
// Conditions raw board inputs before they reach the PS GPIO input bus:
// per-bit 2-flop synchronizer, per-bit debounce counter and a sticky
// change-event register with a toggle-based clear handshake.
// Ports:
//   clk     : system clock (FCLK_CLK0)
//   reset_n : asynchronous active-low reset
//   bus     : slave side of gpio_input_conditioner_if (raw_in, ack_toggle,
//             ack_mask in; level_out, event_pending, ack_echo, irq out)
// -----------------------------------------------------------------------------
module gpio_input_conditioner #(
   parameter  int WIDTH           = 6,
   parameter  int DEBOUNCE_CYCLES = 100000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   gpio_input_conditioner_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] level_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] set_vec;
   logic [WIDTH-1:0] pend_q;
   logic [WIDTH-1:0] pend_d;
   logic             t1_q;
   logic             t2_q;
   logic             t3_q;
   logic             clear_req;

   // Debounce: a bit must disagree with its accepted level for DEBOUNCE_CYCLES
   // consecutive synchronized samples; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      set_vec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = s2_q[i];
            cnt_d[i]   = '0;
            set_vec[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // One clear per ack_toggle transition, seen as an edge between the last
   // two synchronizer stages. Sets are OR'ed in after the clear so an event
   // arriving on the clear edge is never lost.
   assign clear_req = t2_q ^ t3_q;

   always_comb begin
      pend_d = pend_q | set_vec;
      if (clear_req) begin
         pend_d = (pend_q & ~bus.ack_mask) | set_vec;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         pend_q  <= '0;
         t1_q    <= 1'b0;
         t2_q    <= 1'b0;
         t3_q    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q    <= bus.raw_in;
         s2_q    <= s1_q;
         level_q <= level_d;
         pend_q  <= pend_d;
         t1_q    <= bus.ack_toggle;
         t2_q    <= t1_q;
         t3_q    <= t2_q;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.level_out     = level_q;
   assign bus.event_pending = pend_q;
   assign bus.ack_echo      = t3_q;
   assign bus.irq           = |pend_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_conditioner
// Directed stimulus for the input conditioner with DEBOUNCE_CYCLES=4, WIDTH=6.
// A window-based reference model (level flips once the last D synchronized
// samples all disagree with it; clears happen two edges after a toggle is
// sampled) is compared against the DUT on every falling edge, and literal
// expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_gpio_input_conditioner;
   localparam int W = 6;
   localparam int D = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   gpio_input_conditioner_if #(.WIDTH(W)) bus ();

   gpio_input_conditioner #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b required %b", name, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: history of raw samples per edge (rq[0] = this edge),
   // history of ack_toggle samples (aq[0] = this edge).
   logic [W-1:0] rq [0:D+1];
   logic         aq [0:3];
   logic [W-1:0] m_level;
   logic [W-1:0] m_pend;
   logic         m_echo;

   initial begin
      logic [W-1:0] flips;
      logic         steady;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            for (int k = 0; k <= D + 1; k++) rq[k] = '0;
            for (int k = 0; k < 4; k++) aq[k] = 1'b0;
            m_level = '0;
            m_pend  = '0;
            m_echo  = 1'b0;
         end else begin
            for (int k = D + 1; k > 0; k--) rq[k] = rq[k-1];
            rq[0] = bus.raw_in;
            for (int k = 3; k > 0; k--) aq[k] = aq[k-1];
            aq[0] = bus.ack_toggle;
            flips = '0;
            for (int i = 0; i < W; i++) begin
               steady = 1'b1;
               for (int j = 2; j <= D + 1; j++)
                  if (rq[j][i] == m_level[i]) steady = 1'b0;
               flips[i] = steady;
            end
            m_level = m_level ^ flips;
            if (aq[2] != aq[3]) m_pend = (m_pend & ~bus.ack_mask) | flips;
            else                m_pend = m_pend | flips;
            m_echo = aq[2];
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("model level_out",     bus.level_out,     m_level);
         chk("model event_pending", bus.event_pending, m_pend);
         chk("model ack_echo",      W'(bus.ack_echo),  W'(m_echo));
         chk("model irq",           W'(bus.irq),       W'(|m_pend));
      end
   end

   initial begin
      bus.raw_in     = '0;
      bus.ack_toggle = 1'b0;
      bus.ack_mask   = '0;
      cyc(3);
      reset_n = 1'b1;

      // Reset state
      chk("reset level_out",     bus.level_out,     6'b000000);
      chk("reset event_pending", bus.event_pending, 6'b000000);
      chk("reset ack_echo",      W'(bus.ack_echo),  6'b0);
      chk("reset irq",           W'(bus.irq),       6'b0);

      // Bit 0 rises: accepted at edge 6, not earlier
      bus.raw_in[0] = 1'b1;
      cyc(5);
      chk("b0 edge5 level", bus.level_out,     6'b000000);
      chk("b0 edge5 event", bus.event_pending, 6'b000000);
      chk("b0 edge5 irq",   W'(bus.irq),       6'b0);
      cyc(1);
      chk("b0 edge6 level", bus.level_out,     6'b000001);
      chk("b0 edge6 event", bus.event_pending, 6'b000001);
      chk("b0 edge6 irq",   W'(bus.irq),       6'b1);

      // Bit 1: 3-cycle pulse filtered, 4-cycle pulse accepted
      bus.raw_in[1] = 1'b1;
      cyc(3);
      bus.raw_in[1] = 1'b0;
      cyc(8);
      chk("b1 short level", bus.level_out,     6'b000001);
      chk("b1 short event", bus.event_pending, 6'b000001);
      bus.raw_in[1] = 1'b1;
      cyc(4);
      bus.raw_in[1] = 1'b0;
      cyc(2);
      chk("b1 rise edge6", bus.level_out, 6'b000011);
      cyc(3);
      chk("b1 hold edge9", bus.level_out, 6'b000011);
      cyc(1);
      chk("b1 fall edge10 level", bus.level_out,     6'b000001);
      chk("b1 fall edge10 event", bus.event_pending, 6'b000011);

      // Bit 2 bounce 1,0,1,0,1 then held high: final run starts at edge 5
      for (int k = 0; k < 5; k++) begin
         bus.raw_in[2] = (k % 2 == 0);
         cyc(1);
      end
      cyc(4);
      chk("b2 bounce edge9",  bus.level_out, 6'b000001);
      cyc(1);
      chk("b2 bounce edge10", bus.level_out, 6'b000101);
      chk("b2 bounce event",  bus.event_pending, 6'b000111);

      // Clear everything
      bus.ack_mask   = 6'b111111;
      bus.ack_toggle = 1'b1;
      cyc(2);
      chk("clrall edge2 echo",  W'(bus.ack_echo),  6'b0);
      chk("clrall edge2 event", bus.event_pending, 6'b000111);
      cyc(1);
      chk("clrall edge3 echo",  W'(bus.ack_echo),  6'b1);
      chk("clrall edge3 event", bus.event_pending, 6'b000000);
      chk("clrall edge3 irq",   W'(bus.irq),       6'b0);

      // Events on bits 0 and 3, then masked clears
      bus.raw_in[0] = 1'b0;
      bus.raw_in[3] = 1'b1;
      cyc(6);
      chk("b03 event", bus.event_pending, 6'b001001);
      chk("b03 level", bus.level_out,     6'b001100);
      bus.ack_mask   = 6'b000001;
      bus.ack_toggle = 1'b0;
      cyc(2);
      chk("clr0 edge2 echo",  W'(bus.ack_echo),  6'b1);
      chk("clr0 edge2 event", bus.event_pending, 6'b001001);
      cyc(1);
      chk("clr0 edge3 echo",  W'(bus.ack_echo),  6'b0);
      chk("clr0 edge3 event", bus.event_pending, 6'b001000);
      chk("clr0 edge3 irq",   W'(bus.irq),       6'b1);
      bus.ack_mask   = 6'b001000;
      bus.ack_toggle = 1'b1;
      cyc(3);
      chk("clr3 echo",  W'(bus.ack_echo),  6'b1);
      chk("clr3 event", bus.event_pending, 6'b000000);
      chk("clr3 irq",   W'(bus.irq),       6'b0);

      // Bit 4 accepted on the same edge as a clear selecting bit 4
      bus.raw_in[4] = 1'b1;
      cyc(3);
      bus.ack_mask   = 6'b010000;
      bus.ack_toggle = 1'b0;
      cyc(2);
      chk("b4 edge5 event", bus.event_pending, 6'b000000);
      cyc(1);
      chk("b4 collide event", bus.event_pending, 6'b010000);
      chk("b4 collide echo",  W'(bus.ack_echo),  6'b0);
      chk("b4 collide level", bus.level_out,     6'b011100);

      // Reset mid-count (bit 5 cnt=2) with a toggle in flight
      bus.raw_in[5] = 1'b1;
      cyc(2);
      bus.ack_toggle = 1'b1;
      cyc(2);
      chk("pre-reset level", bus.level_out,     6'b011100);
      chk("pre-reset event", bus.event_pending, 6'b010000);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async reset level", bus.level_out,     6'b000000);
      chk("async reset event", bus.event_pending, 6'b000000);
      chk("async reset echo",  W'(bus.ack_echo),  6'b0);
      chk("async reset irq",   W'(bus.irq),       6'b0);
      bus.raw_in     = '0;
      bus.ack_toggle = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(10);
      chk("post-reset level", bus.level_out,     6'b000000);
      chk("post-reset event", bus.event_pending, 6'b000000);
      chk("post-reset echo",  W'(bus.ack_echo),  6'b0);
      chk("post-reset irq",   W'(bus.irq),       6'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
